// File: rtl/apb_gpio_dbint.sv
// apb_gpio_dbint: APB3 GPIO with per-pin sync, shared-threshold debounce and sticky W1C interrupts
module apb_gpio_dbint #(
    parameter int IO_NUM = 8,
    parameter int DB_W = 8,
    parameter logic [DB_W-1:0] DB_RESET = '0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] GPIO_OUT,
    output logic [IO_NUM-1:0] GPIO_OE,
    output logic [IO_NUM-1:0] INT,
    output logic              INT_OR
);
    logic [5:0]        idx;
    logic              acc, err, wr;
    logic [IO_NUM-1:0] data_out, oe, int_en, int_edge, int_pol, int_both, int_stat;
    logic [IO_NUM-1:0] sync1, sync2, stable, prev;
    logic [IO_NUM-1:0] rise, fall, edge_ev, level_ev, ev, w1c, stat_next;
    logic [DB_W-1:0]   debounce;
    logic [31:0]       rd;
    logic              int_or_q;
    logic              unused_ok;

    assign idx = PADDR[7:2];
    assign acc = PSEL & PENABLE;
    assign err = acc & ((idx > 6'd8) | (PWRITE & (idx == 6'd0)));
    assign wr = acc & PWRITE & ~err;
    assign PSLVERR = err;
    assign PREADY = 1'b1;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    always_comb begin
        rd = '0;
        case (idx)
            6'd0: rd = 32'(stable);
            6'd1: rd = 32'(data_out);
            6'd2: rd = 32'(oe);
            6'd3: rd = 32'(int_en);
            6'd4: rd = 32'(int_edge);
            6'd5: rd = 32'(int_pol);
            6'd6: rd = 32'(int_both);
            6'd7: rd = 32'(int_stat);
            6'd8: rd = 32'(debounce);
            default: rd = '0;
        endcase
    end
    assign PRDATA = PSEL ? rd : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            data_out <= '0;
            oe       <= '0;
            int_en   <= '0;
            int_edge <= '0;
            int_pol  <= '0;
            int_both <= '0;
            debounce <= DB_RESET;
        end else if (wr) begin
            case (idx)
                6'd1: data_out <= PWDATA[IO_NUM-1:0];
                6'd2: oe       <= PWDATA[IO_NUM-1:0];
                6'd3: int_en   <= PWDATA[IO_NUM-1:0];
                6'd4: int_edge <= PWDATA[IO_NUM-1:0];
                6'd5: int_pol  <= PWDATA[IO_NUM-1:0];
                6'd6: int_both <= PWDATA[IO_NUM-1:0];
                6'd8: debounce <= PWDATA[DB_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= GPIO_IN;
            sync2 <= sync1;
        end
    end

    // >= rather than == so lowering DEBOUNCE mid-count commits on the next mismatch
    for (genvar i = 0; i < IO_NUM; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            st;
        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                cnt <= '0;
                st  <= 1'b0;
            end else if (debounce == '0) begin
                cnt <= '0;
                st  <= sync2[i];
            end else if (sync2[i] == st) begin
                cnt <= '0;
            end else if (cnt >= debounce - DB_W'(1)) begin
                cnt <= '0;
                st  <= sync2[i];
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
        assign stable[i] = st;
    end

    assign rise = stable & ~prev;
    assign fall = ~stable & prev;
    assign edge_ev = (int_both & (rise | fall)) | (~int_both & ((int_pol & rise) | (~int_pol & fall)));
    assign level_ev = (int_pol & stable) | (~int_pol & ~stable);
    assign ev = (int_edge & edge_ev) | (~int_edge & level_ev);
    assign w1c = (wr && idx == 6'd7) ? PWDATA[IO_NUM-1:0] : '0;
    assign stat_next = (int_stat & ~w1c) | (ev & int_en);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            prev     <= '0;
            int_stat <= '0;
            int_or_q <= 1'b0;
        end else begin
            prev     <= stable;
            int_stat <= stat_next;
            int_or_q <= |stat_next;
        end
    end

    assign GPIO_OUT = data_out;
    assign GPIO_OE = oe;
    assign INT = int_stat;
    assign INT_OR = int_or_q;
endmodule

// File: tb/tb_apb_gpio_dbint.sv
// tb_apb_gpio_dbint: directed self-checking bench for apb_gpio_dbint
module tb_apb_gpio_dbint;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  GPIO_IN = '0;
    logic [7:0]  GPIO_OUT, GPIO_OE, INT;
    logic        INT_OR;
    int          total = 0, bad = 0;
    logic [31:0] d;
    logic        e;

    apb_gpio_dbint #(.IO_NUM(8), .DB_W(8), .DB_RESET(8'd3)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .INT(INT), .INT_OR(INT_OR)
    );

    always #5 PCLK = ~PCLK;

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] v, output logic er);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = v;
        @(posedge PCLK); #1 PENABLE = 1;
        #1 er = PSLVERR;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] v, output logic er);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1 PENABLE = 1;
        #1 v = PRDATA; er = PSLVERR;
        @(posedge PCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({GPIO_OUT, GPIO_OE, INT, INT_OR} !== 25'd0 || PRDATA !== 32'd0 || PREADY !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h oe=%h int=%h or=%b prdata=%h", GPIO_OUT, GPIO_OE, INT, INT_OR, PRDATA);
        end
        @(posedge PCLK); #1 PRESET = 0;
        apb_rd(8'h20, d, e);
        total++;
        if (d !== 32'd3) begin bad++; $display("FAIL reset_debounce: got %h want 00000003", d); end
    endtask

    task automatic test_regs;
        apb_wr(8'h04, 32'hA5, e);
        total++;
        if (GPIO_OUT !== 8'hA5) begin bad++; $display("FAIL gpio_out: got %h want a5", GPIO_OUT); end
        apb_wr(8'h08, 32'h0F, e);
        total++;
        if (GPIO_OE !== 8'h0F) begin bad++; $display("FAIL gpio_oe: got %h want 0f", GPIO_OE); end
        apb_rd(8'h04, d, e);
        total++;
        if (d !== 32'hA5) begin bad++; $display("FAIL rd_data_out: got %h want a5", d); end
        apb_rd(8'h08, d, e);
        total++;
        if (d !== 32'h0F) begin bad++; $display("FAIL rd_oe: got %h want 0f", d); end
        apb_wr(8'h18, 32'hFFFF_FF00, e);
        apb_rd(8'h18, d, e);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL upper_bits: got %h want 0", d); end
        apb_wr(8'h20, 32'h1FF, e);
        apb_rd(8'h20, d, e);
        total++;
        if (d !== 32'hFF) begin bad++; $display("FAIL debounce_width: got %h want ff", d); end
    endtask

    task automatic test_debounce;
        apb_wr(8'h20, 32'd4, e);
        PSEL = 1; PADDR = 8'h00;
        GPIO_IN[0] = 1; cyc(3); GPIO_IN[0] = 0; cyc(8);
        total++;
        if (PRDATA[0] !== 1'b0) begin bad++; $display("FAIL glitch_reject: got %b want 0", PRDATA[0]); end
        GPIO_IN[0] = 1; cyc(5);
        total++;
        if (PRDATA[0] !== 1'b0) begin bad++; $display("FAIL db_early: got %b want 0", PRDATA[0]); end
        cyc(1);
        total++;
        if (PRDATA[0] !== 1'b1) begin bad++; $display("FAIL db_commit: got %b want 1", PRDATA[0]); end
        GPIO_IN[0] = 0; cyc(8);
        total++;
        if (PRDATA[0] !== 1'b0) begin bad++; $display("FAIL db_fall: got %b want 0", PRDATA[0]); end
        PSEL = 0;
    endtask

    task automatic test_bypass;
        apb_wr(8'h20, 32'd0, e);
        PSEL = 1; PADDR = 8'h00;
        GPIO_IN[3] = 1; cyc(2);
        total++;
        if (PRDATA[3] !== 1'b0) begin bad++; $display("FAIL bypass_early: got %b want 0", PRDATA[3]); end
        cyc(1);
        total++;
        if (PRDATA[3] !== 1'b1) begin bad++; $display("FAIL bypass_follow: got %b want 1", PRDATA[3]); end
        GPIO_IN[3] = 0; cyc(5);
        GPIO_IN[3] = 1; cyc(1); GPIO_IN[3] = 0; cyc(2);
        total++;
        if (PRDATA[3] !== 1'b1) begin bad++; $display("FAIL bypass_glitch_seen: got %b want 1", PRDATA[3]); end
        cyc(1);
        total++;
        if (PRDATA[3] !== 1'b0) begin bad++; $display("FAIL bypass_glitch_gone: got %b want 0", PRDATA[3]); end
        PSEL = 0;
    endtask

    task automatic test_edge;
        apb_wr(8'h10, 32'h0E, e);
        apb_wr(8'h14, 32'h02, e);
        apb_wr(8'h18, 32'h08, e);
        apb_wr(8'h0C, 32'h0E, e);
        GPIO_IN = 8'h0E; cyc(6);
        apb_rd(8'h1C, d, e);
        total++;
        if (d !== 32'h0A || INT !== 8'h0A || INT_OR !== 1'b1) begin
            bad++; $display("FAIL edge_rise: got stat=%h int=%h or=%b want 0a 0a 1", d, INT, INT_OR);
        end
        GPIO_IN = 8'h00; cyc(6);
        apb_rd(8'h1C, d, e);
        total++;
        if (d !== 32'h0E || INT !== 8'h0E) begin bad++; $display("FAIL edge_fall: got stat=%h int=%h want 0e", d, INT); end
        apb_wr(8'h1C, 32'h0E, e);
        total++;
        if (INT !== 8'h00 || INT_OR !== 1'b0) begin bad++; $display("FAIL edge_w1c: got int=%h or=%b want 00 0", INT, INT_OR); end
        apb_rd(8'h1C, d, e);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL edge_w1c_rd: got %h want 0", d); end
    endtask

    task automatic test_level;
        apb_wr(8'h14, 32'h10, e);
        apb_wr(8'h0C, 32'h10, e);
        GPIO_IN = 8'h10; cyc(6);
        total++;
        if (INT !== 8'h10 || INT_OR !== 1'b1) begin bad++; $display("FAIL level_set: got int=%h or=%b want 10 1", INT, INT_OR); end
        apb_wr(8'h1C, 32'h10, e);
        total++;
        if (INT !== 8'h10) begin bad++; $display("FAIL level_race: got int=%h want 10", INT); end
        GPIO_IN = 8'h00; cyc(6);
        apb_wr(8'h0C, 32'h00, e);
        apb_rd(8'h1C, d, e);
        total++;
        if (d !== 32'h10) begin bad++; $display("FAIL level_sticky: got %h want 10", d); end
        apb_wr(8'h1C, 32'h10, e);
        apb_rd(8'h1C, d, e);
        total++;
        if (d !== 32'h0 || INT_OR !== 1'b0) begin bad++; $display("FAIL level_clear: got stat=%h or=%b want 0 0", d, INT_OR); end
    endtask

    task automatic test_errors;
        apb_wr(8'h00, 32'hFF, e);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_wr_datain: got pslverr=%b want 1", e); end
        apb_rd(8'h24, d, e);
        total++;
        if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_rd_unmapped: got pslverr=%b prdata=%h want 1 0", e, d); end
        apb_wr(8'h40, 32'h00, e);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_wr_unmapped: got pslverr=%b want 1", e); end
        apb_rd(8'h04, d, e);
        total++;
        if (e !== 1'b0 || d !== 32'hA5 || GPIO_OUT !== 8'hA5) begin
            bad++; $display("FAIL err_no_effect: got pslverr=%b data_out=%h pin=%h want 0 a5 a5", e, d, GPIO_OUT);
        end
    endtask

    task automatic test_midreset;
        apb_wr(8'h0C, 32'h10, e);
        GPIO_IN = 8'h10; cyc(6);
        total++;
        if (INT !== 8'h10) begin bad++; $display("FAIL pre_reset_int: got %h want 10", INT); end
        #3 PRESET = 1;
        #1;
        total++;
        if ({GPIO_OUT, GPIO_OE, INT, INT_OR} !== 25'd0) begin
            bad++; $display("FAIL async_reset: got out=%h oe=%h int=%h or=%b want 0", GPIO_OUT, GPIO_OE, INT, INT_OR);
        end
        @(posedge PCLK); #1 PRESET = 0;
        GPIO_IN = 8'h00;
        apb_rd(8'h20, d, e);
        total++;
        if (d !== 32'd3) begin bad++; $display("FAIL reset_debounce2: got %h want 3", d); end
        apb_rd(8'h04, d, e);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_data_out: got %h want 0", d); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_debounce;
        test_bypass;
        test_edge;
        test_level;
        test_errors;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
